// File: rtl/data_mem_lsu_if.sv
// Request/response bus between a load/store client and data_mem_lsu.
//   master : drives req_* fields, observes req_ready and resp_*
//   slave  : the memory side (data_mem_lsu)
interface data_mem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_lsu.sv
// Data memory with a byte/half/word load-store unit front end.
// One request at a time: IDLE accepts, WAIT burns WAIT_STATES cycles,
// RESP pulses resp_valid for one cycle. The array is accessed on the
// edge that enters RESP.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (also clears the array)
//   bus    : data_mem_lsu_if.slave (req_* in, req_ready/resp_* out)
//
// Parameters
//   DEPTH        : number of 32-bit words, power of two, >= 4
//   WAIT_STATES  : extra access cycles per request, 0..15
//
// Build option
//   DMEM_MISALIGN_CHK_EN : when defined, misaligned half/word accesses
//                          return resp_err; otherwise they are force-aligned.
module data_mem_lsu #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic          clk,
   input logic          rst_n,
   data_mem_lsu_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES == 0) ? CNT_W'(0) : CNT_W'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
   } req_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   req_t              r_req;
   req_t              w_req_in;
   req_t              w_req;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [31:0]       r_resp_rdata;
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept;
   logic              w_enter_resp;
   logic              w_err;
   logic [IDX_W-1:0]  w_idx;
   logic [1:0]        w_lane;
   logic [3:0]        w_be;
   logic [31:0]       w_mask;
   logic [31:0]       w_wdata_lane;
   logic [31:0]       w_rword;
   logic [7:0]        w_rbyte;
   logic [15:0]       w_rhalf;
   logic [31:0]       w_rdata_ext;

   assign w_req_in = '{we:    bus.req_we,
                       addr:  bus.req_addr,
                       size:  bus.req_size,
                       uns:   bus.req_unsigned,
                       wdata: bus.req_wdata};

   assign w_accept = (r_state == S_IDLE) && bus.req_valid;

   // With zero wait states the access happens on the acceptance edge,
   // before the captured copy exists, so use the live inputs in IDLE.
   assign w_req = (r_state == S_IDLE) ? w_req_in : r_req;

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (WAIT_STATES == 0) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) w_state_nxt = S_RESP;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_resp = (w_state_nxt == S_RESP);

   // Address decode; upper address bits are ignored so accesses wrap
   assign w_idx  = w_req.addr[IDX_W+1:2];
   assign w_lane = w_req.addr[1:0];

   // Error detection
   always_comb begin
      w_err = (w_req.size == 2'b11);
`ifdef DMEM_MISALIGN_CHK_EN
      if ((w_req.size == 2'b01) && w_lane[0])      w_err = 1'b1;
      if ((w_req.size == 2'b10) && (w_lane != 2'b00)) w_err = 1'b1;
`endif
   end

   // Store lane enables and lane-replicated write data
   always_comb begin
      w_be         = 4'b0000;
      w_wdata_lane = 32'h0;
      case (w_req.size)
         2'b00: begin
            w_be[w_lane] = 1'b1;
            w_wdata_lane = {4{w_req.wdata[7:0]}};
         end
         2'b01: begin
            w_be         = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata_lane = {2{w_req.wdata[15:0]}};
         end
         2'b10: begin
            w_be         = 4'b1111;
            w_wdata_lane = w_req.wdata;
         end
         default: ;
      endcase
   end

   assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

   // Load lane select and extension
   assign w_rword = r_mem[w_idx];
   assign w_rbyte = w_rword[8*w_lane +: 8];
   assign w_rhalf = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

   always_comb begin
      w_rdata_ext = 32'h0;
      case (w_req.size)
         2'b00:   w_rdata_ext = w_req.uns ? {24'h0, w_rbyte}
                                          : {{24{w_rbyte[7]}}, w_rbyte};
         2'b01:   w_rdata_ext = w_req.uns ? {16'h0, w_rhalf}
                                          : {{16{w_rhalf[15]}}, w_rhalf};
         2'b10:   w_rdata_ext = w_rword;
         default: w_rdata_ext = 32'h0;
      endcase
   end

   // State, captured request and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_req        <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'h0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         if (w_accept) r_req <= w_req_in;
         r_req_ready  <= (w_state_nxt == S_IDLE);
         r_resp_valid <= w_enter_resp;
         r_resp_err   <= w_enter_resp && w_err;
         r_resp_rdata <= (w_enter_resp && !w_err && !w_req.we) ? w_rdata_ext : 32'h0;
      end
   end

   // Storage array; reset clears every word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
      end else if (w_enter_resp && w_req.we && !w_err) begin
         r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (w_wdata_lane & w_mask);
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu: one instance with zero
// wait states (DEPTH 1024) and one with three wait states.
module tb_data_mem_lsu;

   logic clk;
   logic rst0_n;
   logic rst3_n;
   int   n_checks;
   int   n_errors;

   data_mem_lsu_if if0 ();
   data_mem_lsu_if if3 ();

   data_mem_lsu #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
      .clk   (clk),
      .rst_n (rst0_n),
      .bus   (if0.slave)
   );

   data_mem_lsu #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
      .clk   (clk),
      .rst_n (rst3_n),
      .bus   (if3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic set_req(input bit sel, input logic v, input logic we, input logic [31:0] a,
                          input logic [1:0] sz, input logic u, input logic [31:0] wd);
      if (sel) begin
         if3.req_valid = v; if3.req_we = we; if3.req_addr = a;
         if3.req_size = sz; if3.req_unsigned = u; if3.req_wdata = wd;
      end else begin
         if0.req_valid = v; if0.req_we = we; if0.req_addr = a;
         if0.req_size = sz; if0.req_unsigned = u; if0.req_wdata = wd;
      end
   endtask

   function automatic logic get_ready(input bit sel);
      return sel ? if3.req_ready : if0.req_ready;
   endfunction
   function automatic logic get_valid(input bit sel);
      return sel ? if3.resp_valid : if0.resp_valid;
   endfunction
   function automatic logic get_err(input bit sel);
      return sel ? if3.resp_err : if0.resp_err;
   endfunction
   function automatic logic [31:0] get_rdata(input bit sel);
      return sel ? if3.resp_rdata : if0.resp_rdata;
   endfunction

   // One request; checks handshake, latency and the one-cycle pulse.
   // Inputs are scrambled right after acceptance to prove they are captured.
   task automatic access(input bit sel, input string tag, input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic u, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err);
      int  k;
      bit  got;
      int  ws;
      ws = sel ? 3 : 0;
      check({tag, "_rdy"}, 32'(get_ready(sel)), 32'd1);
      set_req(sel, 1'b1, we, a, sz, u, wd);
      @(posedge clk); #1;
      set_req(sel, 1'b0, ~we, ~a, ~sz, ~u, ~wd);
      check({tag, "_busy"}, 32'(get_ready(sel)), 32'd0);
      got = 1'b0; k = 0; rdata = 32'hx; err = 1'bx;
      while (!got && k < 40) begin
         if (get_valid(sel)) begin
            got = 1'b1; rdata = get_rdata(sel); err = get_err(sel);
         end else begin
            @(posedge clk); #1; k++;
         end
      end
      check({tag, "_lat"}, 32'(k + 1), 32'(ws + 1));
      @(posedge clk); #1;
      check({tag, "_pulse"}, {30'h0, get_valid(sel), get_ready(sel)}, 32'h1);
   endtask

   logic [31:0] rd;
   logic        er;
   bit          seen;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst0_n = 1'b0;
      rst3_n = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready0", 32'(if0.req_ready), 32'd1);
      check("rst_valid0", 32'(if0.resp_valid), 32'd0);
      check("rst_err0",   32'(if0.resp_err), 32'd0);
      check("rst_rdata0", if0.resp_rdata, 32'h0);
      check("rst_ready3", 32'(if3.req_ready), 32'd1);
      rst0_n = 1'b1;
      rst3_n = 1'b1;
      @(posedge clk); #1;

      // Word store/load
      access(0, "sw10", 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, rd, er);
      check("sw10_rd", rd, 32'h0);
      check("sw10_err", 32'(er), 32'd0);
      access(0, "lw10", 0, 32'h10, 2'b10, 0, 32'h0, rd, er);
      check("lw10_rd", rd, 32'hDEADBEEF);

      // Byte lanes and extension
      access(0, "sb11", 1, 32'h11, 2'b00, 0, 32'hFFFFFF7F, rd, er);
      access(0, "lbu11", 0, 32'h11, 2'b00, 1, 32'h0, rd, er);
      check("lbu11_rd", rd, 32'h0000007F);
      access(0, "sb13", 1, 32'h13, 2'b00, 0, 32'h00000080, rd, er);
      access(0, "lb13", 0, 32'h13, 2'b00, 0, 32'h0, rd, er);
      check("lb13_rd", rd, 32'hFFFFFF80);
      access(0, "lw10b", 0, 32'h10, 2'b10, 0, 32'h0, rd, er);
      check("lw10b_rd", rd, 32'h80AD7FEF);
      access(0, "lwu10", 0, 32'h10, 2'b10, 1, 32'h0, rd, er);
      check("lwu10_rd", rd, 32'h80AD7FEF);
      access(0, "lh12", 0, 32'h12, 2'b01, 0, 32'h0, rd, er);
      check("lh12_rd", rd, 32'hFFFF80AD);
      access(0, "lhu12", 0, 32'h12, 2'b01, 1, 32'h0, rd, er);
      check("lhu12_rd", rd, 32'h000080AD);

      // Half store/load
      access(0, "sh22", 1, 32'h22, 2'b01, 0, 32'h12348001, rd, er);
      access(0, "lh22", 0, 32'h22, 2'b01, 0, 32'h0, rd, er);
      check("lh22_rd", rd, 32'hFFFF8001);
      access(0, "lhu22", 0, 32'h22, 2'b01, 1, 32'h0, rd, er);
      check("lhu22_rd", rd, 32'h00008001);
      access(0, "lw20", 0, 32'h20, 2'b10, 0, 32'h0, rd, er);
      check("lw20_rd", rd, 32'h80010000);

      // Misaligned accesses
      access(0, "lw13", 0, 32'h13, 2'b10, 0, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
      check("lw13_err", 32'(er), 32'd1);
      check("lw13_rd", rd, 32'h0);
`else
      check("lw13_err", 32'(er), 32'd0);
      check("lw13_rd", rd, 32'h80AD7FEF);
`endif
      access(0, "lh23", 0, 32'h23, 2'b01, 0, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
      check("lh23_err", 32'(er), 32'd1);
      check("lh23_rd", rd, 32'h0);
`else
      check("lh23_err", 32'(er), 32'd0);
      check("lh23_rd", rd, 32'hFFFF8001);
`endif

      // Address wrap: 4*DEPTH aliases word 0
      access(0, "swwrap", 1, 32'h1000, 2'b10, 0, 32'h12345678, rd, er);
      access(0, "lw0", 0, 32'h0, 2'b10, 0, 32'h0, rd, er);
      check("lw0_rd", rd, 32'h12345678);

      // Reserved size
      access(0, "ld11", 0, 32'h10, 2'b11, 0, 32'h0, rd, er);
      check("ld11_err", 32'(er), 32'd1);
      check("ld11_rd", rd, 32'h0);
      access(0, "st11", 1, 32'h0, 2'b11, 0, 32'hFFFFFFFF, rd, er);
      check("st11_err", 32'(er), 32'd1);
      access(0, "lw0b", 0, 32'h0, 2'b10, 0, 32'h0, rd, er);
      check("lw0b_rd", rd, 32'h12345678);
      check("lw0b_err", 32'(er), 32'd0);

      // Three wait states
      access(1, "w3_sw44", 1, 32'h44, 2'b10, 0, 32'hA5A55A5A, rd, er);
      access(1, "w3_lw44", 0, 32'h44, 2'b10, 0, 32'h0, rd, er);
      check("w3_lw44_rd", rd, 32'hA5A55A5A);

      // Reset during WAIT aborts the store
      set_req(1'b1, 1'b1, 1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFEF00D);
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
      @(posedge clk); #1;
      rst3_n = 1'b0;
      #2;
      check("w3_rst_ready", 32'(if3.req_ready), 32'd1);
      check("w3_rst_valid", 32'(if3.resp_valid), 32'd0);
      rst3_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (if3.resp_valid) seen = 1'b1;
      end
      check("w3_abort_noresp", 32'(seen), 32'd0);
      access(1, "w3_lw40", 0, 32'h40, 2'b10, 0, 32'h0, rd, er);
      check("w3_lw40_rd", rd, 32'h0);
      access(1, "w3_ld11", 0, 32'h40, 2'b11, 0, 32'h0, rd, er);
      check("w3_ld11_err", 32'(er), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
